seg_display_scheduler: RTL and testbench

SEG_DISPLAY_SCHEDULER -- requirements
Module: seg_display_scheduler

---
 rtl/seg_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/seg_display_scheduler.sv | 126 ++++++++++++
 tb/tb_seg_display_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the segment display scheduler: state encoding,
// blank digit pattern, requester count and a one-hot helper.
// Pure declarations, no logic of its own.
package seg_pkg;

    localparam int          NUM_REQ     = 4;
    localparam logic [7:0]  BLANK_DIGIT = 8'hFF;   // active-low: all segments off

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } segState_t;

    function automatic logic [NUM_REQ-1:0] grantOneHot(input logic [1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select over NUM_REQ requesters, search starting after lastGrant.
// Latency: purely combinational.
// Backpressure: none; valid is low when no requester is asserting.
//
// Ports:
//   req       in   per-requester request bits
//   lastGrant in   index of the previous winner
//   winner    out  index of the first requester found after lastGrant
//   valid     out  high when any request bit is set
module rr_arbiter
    import seg_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         lastGrant,
    output logic [1:0]         winner,
    output logic               valid
);

    logic [1:0] idx;

    // Offset NUM_REQ wraps back to lastGrant itself, so a lone requester
    // can still win again when nobody else is asking.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = lastGrant + 2'(i);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates four frame requesters onto one registered 4-digit display with a minimum dwell.
// Latency: req seen in IDLE at edge k -> digits/ack after edge k+1; next grant no earlier than k+dwellCycles+3.
// Backpressure: requesters hold req until their one-cycle ack; busy is high while a grant is in progress.
//
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   req[3:0], frame0..frame3   requests and their 32-bit active-low frames (digit one in [31:24])
//   dwellCycles                hold time, sampled when the frame is latched
//   clear                      synchronous blank/abort
//   ack[3:0], grantId, busy    grant pulse, winner index, activity flag
//   digitOne..digitFour        registered digit bytes for the strobing driver
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       req,
    input  logic [31:0]      frame0,
    input  logic [31:0]      frame1,
    input  logic [31:0]      frame2,
    input  logic [31:0]      frame3,
    input  logic [CNT_W-1:0] dwellCycles,
    input  logic             clear,
    output logic [3:0]       ack,
    output logic [1:0]       grantId,
    output logic             busy,
    output logic [7:0]       digitOne,
    output logic [7:0]       digitTwo,
    output logic [7:0]       digitThree,
    output logic [7:0]       digitFour
);

    segState_t        state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lastGrant;
    logic [1:0]       arbWinner;
    logic             arbValid;
    logic [31:0]      selFrame;

    rr_arbiter uArb (
        .req       (req),
        .lastGrant (lastGrant),
        .winner    (arbWinner),
        .valid     (arbValid)
    );

    always_comb begin
        selFrame = frame0;
        case (grantId)
            2'd1:    selFrame = frame1;
            2'd2:    selFrame = frame2;
            2'd3:    selFrame = frame3;
            default: selFrame = frame0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (clear) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (arbValid) stateNext = LOAD;
                LOAD:    stateNext = DWELL;
                DWELL:   if (cnt == '0) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Datapath registers. clear wins over everything but leaves lastGrant and
    // grantId alone so fairness survives an abort.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            digitOne   <= BLANK_DIGIT;
            digitTwo   <= BLANK_DIGIT;
            digitThree <= BLANK_DIGIT;
            digitFour  <= BLANK_DIGIT;
            ack        <= '0;
            grantId    <= '0;
            cnt        <= '0;
            lastGrant  <= 2'd3;
        end else begin
            ack <= '0;
            if (clear) begin
                digitOne   <= BLANK_DIGIT;
                digitTwo   <= BLANK_DIGIT;
                digitThree <= BLANK_DIGIT;
                digitFour  <= BLANK_DIGIT;
                cnt        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arbValid) begin
                            grantId   <= arbWinner;
                            lastGrant <= arbWinner;
                        end
                    end
                    LOAD: begin
                        // Frame and dwell are sampled here, not at grant time.
                        digitOne   <= selFrame[31:24];
                        digitTwo   <= selFrame[23:16];
                        digitThree <= selFrame[15:8];
                        digitFour  <= selFrame[7:0];
                        ack        <= grantOneHot(grantId);
                        cnt        <= dwellCycles;
                    end
                    DWELL: begin
                        if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] frame [4];
    logic [31:0] dwellCycles = '0;
    logic        clear = 1'b0;
    logic [3:0]  ack;
    logic [1:0]  grantId;
    logic        busy;
    logic [7:0]  digitOne, digitTwo, digitThree, digitFour;

    int nTests = 0;
    int nFail  = 0;

    seg_display_scheduler #(.CNT_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .frame0      (frame[0]),
        .frame1      (frame[1]),
        .frame2      (frame[2]),
        .frame3      (frame[3]),
        .dwellCycles (dwellCycles),
        .clear       (clear),
        .ack         (ack),
        .grantId     (grantId),
        .busy        (busy),
        .digitOne    (digitOne),
        .digitTwo    (digitTwo),
        .digitThree  (digitThree),
        .digitFour   (digitFour)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] digits();
        return {digitOne, digitTwo, digitThree, digitFour};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        req   = '0;
        clear = 1'b0;
        RST   = 1'b1;
        step();
        chk("rst_digits", digits(), 32'hFFFFFFFF);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_grant", 32'(grantId), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        RST = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    // Timestamp view: a grant at edge e means the frame is taken at e+1 and the
    // display is free for arbitration again at edge (e+1)+dwell+2.
    longint     mEdge, mLoadAt, mFreeAt;
    int         mLast, mGid;
    logic [31:0] mDig;
    logic [3:0] mAck;
    logic       mBusy;

    task automatic mdlReset();
        mEdge = 0; mLoadAt = -1; mFreeAt = 0;
        mLast = 3; mGid = 0; mDig = 32'hFFFFFFFF; mAck = '0; mBusy = 1'b0;
    endtask

    task automatic mdlEdge();
        bit found;
        mAck = '0;
        if (clear) begin
            mLoadAt = -1;
            mFreeAt = mEdge + 1;
            mDig    = 32'hFFFFFFFF;
        end else if (mEdge == mLoadAt) begin
            mDig    = frame[mGid];
            mAck    = 4'(1 << mGid);
            mFreeAt = mEdge + longint'(dwellCycles) + 2;
            mLoadAt = -1;
        end else if (mEdge >= mFreeAt && req != 0) begin
            found = 0;
            for (int o = 1; o <= 4; o++) begin
                int c;
                c = (mLast + o) % 4;
                if (!found && req[c]) begin
                    found = 1; mGid = c;
                end
            end
            mLast   = mGid;
            mLoadAt = mEdge + 1;
        end
        mEdge++;
        mBusy = (mLoadAt == mEdge) || (mEdge < mFreeAt);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic [31:0] frame;
        int          dwell;
        logic [1:0]  gid;
        logic [3:0]  ack;
        int          busyCyc;
    } vec_t;

    vec_t vecs[4];

    logic [3:0] seenAck [$];

    initial begin
        int n;
        for (int j = 0; j < 4; j++) frame[j] = '0;

        vecs[0] = '{4'b0001, 32'hC0F9A4B0, 3, 2'd0, 4'b0001, 5};
        vecs[1] = '{4'b0010, 32'h12345678, 0, 2'd1, 4'b0010, 2};
        vecs[2] = '{4'b1100, 32'hA5A55A5A, 1, 2'd2, 4'b0100, 3};
        vecs[3] = '{4'b1000, 32'hFFFF0000, 2, 2'd3, 4'b1000, 4};

        // Single grants from reset; req dropped during LOAD each time.
        for (int v = 0; v < 4; v++) begin
            doReset();
            for (int j = 0; j < 4; j++)
                frame[j] = (j == int'(vecs[v].gid)) ? vecs[v].frame : ~vecs[v].frame;
            dwellCycles = 32'(vecs[v].dwell);
            req = vecs[v].req;
            step();
            chk("vec_busy_load", 32'(busy), 32'h1);
            chk("vec_gid", 32'(grantId), 32'(vecs[v].gid));
            chk("vec_ack_load", 32'(ack), 32'h0);
            req = '0;
            step();
            chk("vec_digits", digits(), vecs[v].frame);
            chk("vec_ack", 32'(ack), 32'(vecs[v].ack));
            n = 2;
            for (int t = 0; t < 50; t++) begin
                step();
                if (t == 0) chk("vec_ack_pulse", 32'(ack), 32'h0);
                if (busy) n++;
                else break;
            end
            chk("vec_busy_cycles", 32'(n), 32'(vecs[v].busyCyc));
            chk("vec_digits_hold", digits(), vecs[v].frame);
        end

        // All four requesting, zero dwell: strict rotation, one ack every 3 cycles.
        doReset();
        for (int j = 0; j < 4; j++) frame[j] = 32'h11111111 * (j + 1);
        dwellCycles = 0;
        req = 4'b1111;
        seenAck.delete();
        for (int t = 1; t <= 15; t++) begin
            step();
            if (ack != 0) begin
                seenAck.push_back(ack);
                chk("rr4_ack_spacing", 32'(t % 3), 32'h2);
            end
        end
        chk("rr4_ack_count", 32'(seenAck.size()), 32'd5);
        if (seenAck.size() == 5) begin
            chk("rr4_order0", 32'(seenAck[0]), 32'h1);
            chk("rr4_order1", 32'(seenAck[1]), 32'h2);
            chk("rr4_order2", 32'(seenAck[2]), 32'h4);
            chk("rr4_order3", 32'(seenAck[3]), 32'h8);
            chk("rr4_order4", 32'(seenAck[4]), 32'h1);
        end

        // Two requesters held: alternation, no back-to-back wins.
        doReset();
        dwellCycles = 1;
        req = 4'b0101;
        seenAck.delete();
        for (int t = 1; t <= 16; t++) begin
            step();
            if (ack != 0) seenAck.push_back(ack);
        end
        chk("rr2_ack_count", 32'(seenAck.size()), 32'd4);
        for (int i = 0; i < seenAck.size() && i < 4; i++)
            chk("rr2_order", 32'(seenAck[i]), (i % 2 == 0) ? 32'h1 : 32'h4);

        // clear in DWELL with cnt at 5.
        doReset();
        frame[0] = 32'h01020304;
        dwellCycles = 7;
        req = 4'b0001;
        step();                 // grant
        req = '0;
        step();                 // frame taken, cnt=7
        step();                 // cnt=6
        step();                 // cnt=5
        chk("clr_pre_digits", digits(), 32'h01020304);
        clear = 1'b1;
        req = 4'b0010;
        step();
        chk("clr_digits", digits(), 32'hFFFFFFFF);
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_ack", 32'(ack), 32'h0);
        clear = 1'b0;
        step();
        chk("clr_regrant_busy", 32'(busy), 32'h1);
        chk("clr_regrant_gid", 32'(grantId), 32'h1);
        req = '0;
        step();
        chk("clr_regrant_ack", 32'(ack), 32'h2);

        // Asynchronous reset between edges while in LOAD.
        doReset();
        frame[1] = 32'hDEADBEEF;
        frame[2] = 32'hCAFEF00D;
        dwellCycles = 0;
        req = 4'b0010;
        step(); req = '0; step(); step();
        chk("arst_pre_digits", digits(), 32'hDEADBEEF);
        req = 4'b0100;
        step();
        chk("arst_pre_gid", 32'(grantId), 32'h2);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_digits", digits(), 32'hFFFFFFFF);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_gid", 32'(grantId), 32'h0);
        chk("arst_ack", 32'(ack), 32'h0);
        req = '0;
        step();
        RST = 1'b0;
        step();
        chk("arst_no_ack", 32'(ack), 32'h0);
        chk("arst_idle", 32'(busy), 32'h0);
        req = 4'b1001;
        step();
        chk("arst_first_gid", 32'(grantId), 32'h0);

        // Randomized run against the reference model.
        doReset();
        mdlReset();
        for (int t = 0; t < 600; t++) begin
            req   = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 19) == 0);
            dwellCycles = $urandom_range(0, 5);
            for (int j = 0; j < 4; j++) frame[j] = $urandom;
            step();
            mdlEdge();
            chk("rnd_ack", 32'(ack), 32'(mAck));
            chk("rnd_busy", 32'(busy), 32'(mBusy));
            chk("rnd_digits", digits(), mDig);
            chk("rnd_gid", 32'(grantId), 32'(mGid));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
